// File: rtl/team_06_channel_arbiter.sv
// -----------------------------------------------------------------------------
// team_06_channel_arbiter
//
// Half-duplex channel arbiter for the team_06 audio path. Each sample it decides
// whether the link transmits (mic -> TALK/HANG) or listens (speaker -> LISTEN).
// It arbitrates push-to-talk, voice-activated talk (noise gate with attack count
// and open/close hysteresis) and incoming speaker audio. A hang time keeps the
// transmitter up between words, and a listen hold keeps the speaker path up
// between incoming phrases.
//
// Optional feature (compile-time macro TEAM_06_TOT_EN): a transmit timeout.
// It counts strobes spent in TALK/HANG, forces IDLE when the count reaches
// TOT_SAMPLES, and locks out PTT/voice activation until PTT is released with
// a quiet noise gate. When the macro is undefined, tot_flag is tied to 0.
//
// Ports:
//   clk           in   system clock
//   nrst          in   asynchronous active-low reset
//   sample_strobe in   one-cycle pulse, mic_aud/spk_aud valid
//   mic_aud[7:0]  in   mic sample magnitude
//   spk_aud[7:0]  in   incoming speaker sample
//   ptt_en        in   push-to-talk level, acts on any cycle
//   ng_en         in   noise-gate / voice-activation enable
//   mute          in   speaker mute (combinational on vol_en)
//   effect        in   voice effect selected
//   state[1:0]    out  IDLE=00, LISTEN=01, TALK=10, HANG=11
//   tx_en         out  transmit path enabled (TALK or HANG)
//   vol_en        out  speaker volume path enabled (IDLE/LISTEN and not muted)
//   eff_en        out  effect block enabled (tx_en and effect)
//   tot_flag      out  timeout lockout active
// -----------------------------------------------------------------------------
module team_06_channel_arbiter #(
  parameter int unsigned      CNT_W          = 16,
  parameter logic [7:0]       THRESH_OPEN    = 8'd64,
  parameter logic [7:0]       THRESH_CLOSE   = 8'd48,
  parameter int unsigned      ATTACK_SAMPLES = 4,
  parameter logic [CNT_W-1:0] HOLD_SAMPLES   = CNT_W'(800),
  parameter logic [CNT_W-1:0] LISTEN_HOLD    = CNT_W'(800),
  parameter logic [CNT_W-1:0] TOT_SAMPLES    = CNT_W'(40000)
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       sample_strobe,
  input  logic [7:0] mic_aud,
  input  logic [7:0] spk_aud,
  input  logic       ptt_en,
  input  logic       ng_en,
  input  logic       mute,
  input  logic       effect,
  output logic [1:0] state,
  output logic       tx_en,
  output logic       vol_en,
  output logic       eff_en,
  output logic       tot_flag
);

  // Reject configurations the arbiter cannot honour at elaboration time.
  if ((THRESH_CLOSE > THRESH_OPEN) || (ATTACK_SAMPLES < 1) || (HOLD_SAMPLES == '0) ||
      (LISTEN_HOLD == '0) || (TOT_SAMPLES == '0)) begin : g_bad_cfg
    $error("team_06_channel_arbiter: illegal parameter set");
  end

  localparam int unsigned VoxW = $clog2(ATTACK_SAMPLES + 1);
  localparam logic [VoxW-1:0] VoxMax = VoxW'(ATTACK_SAMPLES);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StListen = 2'b01,
    StTalk   = 2'b10,
    StHang   = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [VoxW-1:0]  vox_cnt_q, vox_cnt_d, vox_cnt_upd;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic mic_open;    // strobe with gate enabled and level at/above the open threshold
  logic mic_close;   // strobe with level below the close threshold
  logic spk_act;
  logic vox_open;
  logic enter_quiet; // transition into IDLE or LISTEN this cycle
  logic lockout;
  logic ptt_ok;
  logic vox_ok;

  // ---------------------------------------------------------------------------
  // Per-sample event qualification
  // ---------------------------------------------------------------------------
  always_comb begin
    mic_open  = sample_strobe && ng_en && (mic_aud >= THRESH_OPEN);
    mic_close = sample_strobe && (mic_aud < THRESH_CLOSE);
    spk_act   = sample_strobe && (spk_aud != 8'd0);

    // Attack count including the sample on this strobe, so the gate opens at
    // the edge that consumes the ATTACK_SAMPLES-th qualifying sample.
    vox_cnt_upd = vox_cnt_q;
    if (sample_strobe) begin
      if (mic_open) begin
        vox_cnt_upd = (vox_cnt_q == VoxMax) ? VoxMax : vox_cnt_q + VoxW'(1);
      end else begin
        vox_cnt_upd = '0;
      end
    end
    vox_open = sample_strobe && (vox_cnt_upd == VoxMax);
  end

  assign ptt_ok = ptt_en && !lockout;
  assign vox_ok = vox_open && !lockout;

`ifdef TEAM_06_TOT_EN
  logic [CNT_W-1:0] tot_cnt_q, tot_cnt_d;
  logic             lockout_q, lockout_d;
  logic             tot_hit;

  assign lockout = lockout_q;
  // Reached when the strobe being consumed would bring the count to TOT_SAMPLES.
  assign tot_hit = sample_strobe && state_q[1] && (tot_cnt_q >= TOT_SAMPLES - CNT_W'(1));
`else
  assign lockout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (ptt_ok) begin
          state_d = StTalk;
        end else if (spk_act) begin
          state_d    = StListen;
          hold_cnt_d = LISTEN_HOLD;
        end else if (vox_ok) begin
          state_d = StTalk;
        end
      end

      StListen: begin
        // Voice activation deliberately has no path out of LISTEN.
        if (ptt_ok) begin
          state_d = StTalk;
        end else if (spk_act) begin
          hold_cnt_d = LISTEN_HOLD;
        end else if (sample_strobe) begin
          if (hold_cnt_q <= CNT_W'(1)) begin
            state_d = StIdle;
          end else begin
            hold_cnt_d = hold_cnt_q - CNT_W'(1);
          end
        end
      end

      StTalk: begin
        // Speaker audio is ignored while talking.
        if (!ptt_en && (!ng_en || mic_close)) begin
          state_d    = StHang;
          hold_cnt_d = HOLD_SAMPLES;
        end
      end

      StHang: begin
        if (ptt_ok) begin
          state_d = StTalk;
        end else if (mic_open) begin
          // Resuming speech skips the attack delay.
          state_d = StTalk;
        end else if (spk_act) begin
          state_d    = StListen;
          hold_cnt_d = LISTEN_HOLD;
        end else if (sample_strobe) begin
          if (hold_cnt_q <= CNT_W'(1)) begin
            state_d = StIdle;
          end else begin
            hold_cnt_d = hold_cnt_q - CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

`ifdef TEAM_06_TOT_EN
    // The timeout overrides every other transition.
    if (tot_hit) begin
      state_d = StIdle;
    end
`endif

    enter_quiet = (state_d != state_q) && ((state_d == StIdle) || (state_d == StListen));
    vox_cnt_d   = enter_quiet ? '0 : vox_cnt_upd;
  end

`ifdef TEAM_06_TOT_EN
  always_comb begin
    tot_cnt_d = tot_cnt_q;
    if (enter_quiet) begin
      tot_cnt_d = '0;
    end else if (sample_strobe && state_q[1]) begin
      tot_cnt_d = tot_cnt_q + CNT_W'(1);
    end

    lockout_d = lockout_q;
    if (tot_hit) begin
      lockout_d = 1'b1;
    end else if (lockout_q && !ptt_en && (vox_cnt_q == '0)) begin
      lockout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tot_cnt_q <= '0;
      lockout_q <= 1'b0;
    end else begin
      tot_cnt_q <= tot_cnt_d;
      lockout_q <= lockout_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= StIdle;
      vox_cnt_q  <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      vox_cnt_q  <= vox_cnt_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode; tx_en and vol_en are mutually exclusive by construction.
  // ---------------------------------------------------------------------------
  assign state    = state_q;
  assign tx_en    = state_q[1];
  assign vol_en   = !state_q[1] && !mute;
  assign eff_en   = tx_en && effect;
  assign tot_flag = lockout;

endmodule

// File: doc/team_06_channel_arbiter.md
Name: team_06_channel_arbiter

Overview:
- Half-duplex channel arbiter for the team_06 audio path. Decides per sample whether the link transmits (mic) or listens (speaker).
- Arbitrates push-to-talk, voice-activated talk (noise gate with attack and hysteresis) and incoming speaker audio.
- Adds hang-time so speech is not chopped between words.
- Drives transmit, volume and effect enables for the downstream datapath.

Parameters:
- THRESH_OPEN, 8'd64, mic level at or above which the noise gate counts toward opening.
- THRESH_CLOSE, 8'd48, mic level below which voice-activated talk releases. Must be <= THRESH_OPEN.
- ATTACK_SAMPLES, 4, consecutive qualifying samples needed to open the gate. Must be >= 1.
- HOLD_SAMPLES, 16'd800, talk hang length in samples. Must be >= 1.
- LISTEN_HOLD, 16'd800, silent speaker samples before listen is released. Must be >= 1.
- TOT_SAMPLES, 16'd40000, transmit timeout in samples. Used only with TEAM_06_TOT_EN.
- CNT_W, 16, width of the hold and timeout counters.

Ports:
- clk  in  1  system clock.
- nrst  in  1  asynchronous active-low reset.
- sample_strobe  in  1  one-cycle pulse; mic_aud and spk_aud are valid on this cycle.
- mic_aud  in  8  mic sample magnitude.
- spk_aud  in  8  incoming speaker sample.
- ptt_en  in  1  push-to-talk level. Sampled every clock.
- ng_en  in  1  noise-gate / voice-activation enable.
- mute  in  1  speaker mute.
- effect  in  1  voice effect selected.
- state  out  2  IDLE=00, LISTEN=01, TALK=10, HANG=11.
- tx_en  out  1  transmit path enabled.
- vol_en  out  1  speaker volume path enabled.
- eff_en  out  1  effect block enabled.
- tot_flag  out  1  timeout lockout active.

Behaviour:
- Reset (nrst low, asynchronous):
  - state=IDLE; vox_cnt, hold_cnt and tot_cnt cleared; lockout cleared.
  - Outputs during reset: tx_en=0, eff_en=0, tot_flag=0, vol_en=!mute.
  - Reset asserted mid-talk aborts immediately to IDLE.
- Event qualification:
  - Per-sample events (spk_act, vox_open, mic thresholds) qualify only on cycles where sample_strobe=1.
  - ptt_en acts on any cycle.
- vox_cnt:
  - On each strobe, if ng_en and mic_aud>=THRESH_OPEN, increment, saturating at ATTACK_SAMPLES. Otherwise clear to 0.
  - vox_open = (vox_cnt==ATTACK_SAMPLES).
  - Cleared on any entry to IDLE or LISTEN.
- spk_act = strobe && (spk_aud!=0).
- Output decode:
  - tx_en=1 in TALK and HANG.
  - vol_en = (IDLE or LISTEN) && !mute. mute is applied combinationally.
  - eff_en = tx_en && effect.
  - tx_en and vol_en are never both 1.
- Transition priority is listed top to bottom in each state. All transitions take effect at the next clock edge.
- IDLE:
  - ptt_en -> TALK.
  - spk_act -> LISTEN, hold_cnt=LISTEN_HOLD.
  - vox_open -> TALK.
- LISTEN:
  - ptt_en -> TALK (PTT preempts).
  - spk_act -> reload hold_cnt=LISTEN_HOLD.
  - Strobe with silent speaker: if hold_cnt==1 -> IDLE, else decrement.
  - Voice activation cannot seize the channel in LISTEN.
- TALK:
  - While ptt_en=1, stay. Speaker audio is ignored.
  - If ptt_en=0 and ng_en=0 -> HANG, hold_cnt=HOLD_SAMPLES.
  - If ptt_en=0, ng_en=1 and a strobe has mic_aud<THRESH_CLOSE -> HANG, hold_cnt=HOLD_SAMPLES.
- HANG:
  - ptt_en -> TALK.
  - Strobe with ng_en and mic_aud>=THRESH_OPEN -> TALK (no attack delay).
  - spk_act -> LISTEN, hold_cnt=LISTEN_HOLD.
  - Otherwise, on a strobe: if hold_cnt==1 -> IDLE, else decrement.
- HANG lasts exactly HOLD_SAMPLES strobes absent other events. LISTEN likewise lasts LISTEN_HOLD silent strobes.
- Simultaneous events resolve strictly by the priority lists above.
- Counters never wrap. hold_cnt is only loaded or decremented while >=1.

Optional Feature:
- Macro: TEAM_06_TOT_EN.
- With the macro defined:
  - tot_cnt increments on each strobe in TALK or HANG and clears on entry to IDLE or LISTEN.
  - When tot_cnt reaches TOT_SAMPLES, force state=IDLE and set lockout (tot_flag=1).
  - While lockout is set, ptt_en and vox_open are ignored; LISTEN entry still works.
  - Lockout clears on the first cycle with ptt_en=0 and vox_cnt==0.
- Without the macro: no tot_cnt, tot_flag tied 0, TOT_SAMPLES unused.

Test Plan:
All scenarios use ATTACK=4, HOLD=3, LISTEN_HOLD=3, TOT=8, strobe every 4 clocks.
1. nrst low with mute=0 -> state=00, tx_en=0, vol_en=1. Release nrst, ptt_en=1 for 1 clock -> state=10 next edge, tx_en=1, vol_en=0.
2. ng_en=1, mic_aud=70 for 3 strobes -> still IDLE; 4th strobe -> TALK. Then mic_aud=50 for 5 strobes -> stays TALK (hysteresis). Then mic_aud=10 -> HANG; 3 quiet strobes -> IDLE.
3. IDLE, spk_aud=5 strobe -> LISTEN. ptt_en=1 -> TALK. Drop ptt, ng_en=0 -> HANG. spk_aud=9 strobe -> LISTEN. spk_aud=0 for 3 strobes -> IDLE.
4. LISTEN with ng_en=1, mic_aud=200 for 10 strobes -> stays LISTEN, vol_en=1. Assert mute -> vol_en=0 same cycle.
5. Strobe carrying spk_aud=3 and ng_en=1, mic_aud=80 in HANG -> TALK wins. In TALK, effect=1 -> eff_en=1. nrst pulse -> IDLE, eff_en=0.
6. TEAM_06_TOT_EN: hold ptt_en=1 for 8 strobes -> IDLE, tot_flag=1 while ptt_en stays 1. ptt_en=0 -> tot_flag=0. Re-press -> TALK. Without macro -> TALK held indefinitely, tot_flag=0.
